// File: rtl/shift_pipe_if.sv
// shift_pipe_if: handshake and payload bundle for the pipelined shifter.
//   in_valid/in_ready : producer -> pipeline handshake
//   In, Cnt, Op       : operand, shift amount, operation code
//   out_valid/out_ready : pipeline -> consumer handshake
//   Out, err          : result and illegal-op flag
// The slave modport is the pipeline's view, master is the surrounding logic.
interface shift_pipe_if #(
    parameter int unsigned N = 16,
    parameter int unsigned C = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] In;
    logic [C-1:0] Cnt;
    logic [2:0]   Op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Out;
    logic         err;

    modport master (
        output in_valid, In, Cnt, Op, out_ready,
        input  in_ready, out_valid, Out, err
    );

    modport slave (
        input  in_valid, In, Cnt, Op, out_ready,
        output in_ready, out_valid, Out, err
    );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: C-stage pipelined shifter/rotator on N-bit data (N == 2**C).
// Stage k conditionally shifts by 2**k when Cnt[k] is set, so after C stages
// the full count has been applied. Handshake on both ends with backpressure:
// the whole pipe advances when the output slot is empty or being drained.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of shift_pipe_if (operation in, result out)
module shift_pipe #(
    parameter int unsigned N = 16,
    parameter int unsigned C = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_pipe_if.slave bus
);
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // Stage registers
    logic         vld_q [C];
    logic [N-1:0] dat_q [C];
    logic [C-1:0] cnt_q [C];
    logic [2:0]   op_q  [C];
    logic         err_q [C];

    // Stage inputs (previous stage or the bus) and shifted data
    logic         vld_in [C];
    logic [N-1:0] dat_in [C];
    logic [C-1:0] cnt_in [C];
    logic [2:0]   op_in  [C];
    logic         err_in [C];
    logic [N-1:0] dat_nxt [C];

    logic adv_c;

    // Single fixed-distance shift/rotate; illegal ops pass data through
    function automatic logic [N-1:0] shift_by(
        input logic [N-1:0] d,
        input logic [2:0]   op,
        input int unsigned  sh
    );
        logic [N-1:0] r;
        r = d;
        case (op)
            OP_SLL:  r = d << sh;
            OP_SRL:  r = d >> sh;
            OP_SRA:  r = N'($signed(d) >>> sh);
            OP_ROL:  r = (d << sh) | (d >> (N - sh));
            OP_ROR:  r = (d >> sh) | (d << (N - sh));
            default: r = d;
        endcase
        return r;
    endfunction

    // Whole pipe moves together whenever the output slot can be vacated
    assign adv_c        = !vld_q[C-1] || bus.out_ready;
    assign bus.in_ready = adv_c;

    assign bus.out_valid = vld_q[C-1];
    assign bus.Out       = dat_q[C-1];
    assign bus.err       = err_q[C-1];

    // Stage input selection and per-stage conditional shift
    always_comb begin
        for (int k = 0; k < C; k++) begin
            vld_in[k] = 1'b0;
            dat_in[k] = '0;
            cnt_in[k] = '0;
            op_in[k]  = '0;
            err_in[k] = 1'b0;
            if (k == 0) begin
                vld_in[k] = bus.in_valid;
                dat_in[k] = bus.In;
                cnt_in[k] = bus.Cnt;
                op_in[k]  = bus.Op;
                err_in[k] = (bus.Op > OP_ROR);
            end else begin
                vld_in[k] = vld_q[k-1];
                dat_in[k] = dat_q[k-1];
                cnt_in[k] = cnt_q[k-1];
                op_in[k]  = op_q[k-1];
                err_in[k] = err_q[k-1];
            end
            dat_nxt[k] = cnt_in[k][k] ? shift_by(dat_in[k], op_in[k], 32'(1) << k)
                                      : dat_in[k];
        end
    end

    // Pipeline registers; a bubble enters stage 0 when nothing is offered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < C; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
                cnt_q[k] <= '0;
                op_q[k]  <= '0;
                err_q[k] <= 1'b0;
            end
        end else if (adv_c) begin
            for (int k = 0; k < C; k++) begin
                vld_q[k] <= vld_in[k];
                dat_q[k] <= dat_nxt[k];
                cnt_q[k] <= cnt_in[k];
                op_q[k]  <= op_in[k];
                err_q[k] <= err_in[k];
            end
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// Testbench for shift_pipe: directed literal cases plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_shift_pipe;
    localparam int unsigned N = 16;
    localparam int unsigned C = 4;

    typedef struct {
        logic [N-1:0] d;
        logic         e;
        int           stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q[$];
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_out = '0;

    shift_pipe_if #(.N(N), .C(C)) bus ();

    shift_pipe #(.N(N), .C(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Whole-count reference: shift amount applied in one go
    function automatic exp_t model(input logic [N-1:0] d, input logic [C-1:0] c, input logic [2:0] o);
        exp_t r;
        logic [2*N-1:0] dd;
        logic signed [N-1:0] s;
        dd = {d, d};
        s = d;
        r.e = (o > 3'd4);
        r.stamp = 0;
        case (o)
            3'd0: r.d = d << c;
            3'd1: r.d = d >> c;
            3'd2: r.d = N'(s >>> c);
            3'd3: begin dd = dd << c; r.d = dd[2*N-1:N]; end
            3'd4: begin dd = dd >> c; r.d = dd[N-1:0]; end
            default: r.d = d;
        endcase
        return r;
    endfunction

    // Per-cycle compare; sampled mid-cycle, handshakes complete at next rise
    always @(negedge clk) begin
        exp_t x;
        cyc++;
        if (rst) begin
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out", 32'(bus.Out), 32'd0);
            chk("rst_err", 32'(bus.err), 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (prev_stall) chk("stall_hold", 32'(bus.Out), 32'(prev_out));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected out_valid");
                end else begin
                    chk("sb_out", 32'(bus.Out), 32'(q[0].d));
                    chk("sb_err", 32'(bus.err), 32'(q[0].e));
                    if (cyc - q[0].stamp < int'(C)) fail("result too early");
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out = bus.Out;
            if (bus.in_valid && bus.in_ready) begin
                x = model(bus.In, bus.Cnt, bus.Op);
                x.stamp = cyc;
                q.push_back(x);
            end
        end
    end

    // Present one op starting at posedge+1; returns at posedge+1 after accept
    task automatic drive(input logic [N-1:0] d, input logic [C-1:0] c, input logic [2:0] o);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.In = d;
        bus.Cnt = c;
        bus.Op = o;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) fail("accept timeout");
    endtask

    // Wait for next result and check literal value and latency in cycles
    task automatic wait_result(input string name, input logic [N-1:0] d, input logic e, input int lat);
        bit found;
        found = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk({name, "_lat"}, 32'(n), 32'(lat));
                chk({name, "_out"}, 32'(bus.Out), 32'(d));
                chk({name, "_err"}, 32'(bus.err), 32'(e));
                found = 1;
                break;
            end
        end
        if (!found) fail({name, " result timeout"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] stall_exp [4];
        logic took;
        bus.in_valid = 1'b0;
        bus.In = '0;
        bus.Cnt = '0;
        bus.Op = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed literal cases
        drive(16'h8001, 4'd1, 3'b001);  wait_result("srl1", 16'h4000, 1'b0, 4);
        drive(16'h8001, 4'd1, 3'b000);  wait_result("sll1", 16'h0002, 1'b0, 4);
        drive(16'h8000, 4'd15, 3'b010); wait_result("sra_neg", 16'hFFFF, 1'b0, 4);
        drive(16'h7FFF, 4'd15, 3'b010); wait_result("sra_pos", 16'h0000, 1'b0, 4);
        drive(16'h8000, 4'd15, 3'b001); wait_result("srl_max", 16'h0001, 1'b0, 4);
        drive(16'h0001, 4'd1, 3'b100);  wait_result("ror1", 16'h8000, 1'b0, 4);
        drive(16'h8001, 4'd4, 3'b011);  wait_result("rol4", 16'h0018, 1'b0, 4);
        drive(16'h1234, 4'd0, 3'b011);  wait_result("rol0", 16'h1234, 1'b0, 4);
        drive(16'hABCD, 4'd5, 3'b110);  wait_result("illegal", 16'hABCD, 1'b1, 4);

        // Back-to-back ops, then stall the output for 3 cycles
        stall_exp[0] = 16'hF000; stall_exp[1] = 16'h7800;
        stall_exp[2] = 16'h3C00; stall_exp[3] = 16'h1E00;
        for (int i = 0; i < 4; i++) drive(16'hF000, 4'(i), 3'b001);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_out", 32'(bus.Out), 32'hF000);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_out", 32'(bus.Out), 32'(stall_exp[i]));
        end
        @(posedge clk);
        #1;

        // Reset with operations in flight
        for (int i = 0; i < 3; i++) drive(16'h00FF, 4'(i + 1), 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out", 32'(bus.Out), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("postrst_quiet", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        drive(16'h0F0F, 4'd4, 3'b100);  wait_result("postrst", 16'hF0F0, 1'b0, 4);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (!bus.in_valid || took) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.In = N'($urandom);
                bus.Cnt = C'($urandom);
                bus.Op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                     : 3'($urandom_range(0, 4));
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3 * C + 4) @(posedge clk);
        @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_idle", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
